rename_ckpt: RTL and testbench

- Parametrised successor to the 4-wide rename stage: maps up to WAYS architectural {rd, rs2, rs1} triples per cycle to physical registers.
- Resolves intra-group RAW and WAW dependencies.
- Returns the old prd of each rd for commit-time freeing.
- Adds branch checkpoints with single-cycle map-table recovery, a ready/stall handshake, and per-way valids.
- Sits between decode and dispatch; fed by the freelist.

---
 rtl/rename_pkg.sv | 22 ++
 rtl/rename_maptable_ckpt.sv | 42 ++++
 rtl/rename_ckpt.sv | 183 ++++++++++++++++++
 tb/tb_rename_ckpt.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared rename constants: architectural register width, triple layout.
// Exports AREG_W, NAREG, ZERO_REG, field offsets and popcount().
package rename_pkg;

  localparam int AREG_W = 5;
  localparam int NAREG  = 32;
  localparam logic [AREG_W-1:0] ZERO_REG = '0;

  localparam int RS1_LSB = 0;
  localparam int RS2_LSB = 5;
  localparam int RD_LSB  = 10;
  localparam int RG_W    = 15;

  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++)
      n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/rename_maptable_ckpt.sv
// Architectural-to-physical map table with NCKPT snapshot banks.
// Ports: clk/rst, upd+next_map, snap_we/snap_id/snap_map, restore/restore_id, map.
module rename_maptable_ckpt
  import rename_pkg::*;
#(
  parameter int WIDTH_PRD = 7,
  parameter int NCKPT     = 4,
  parameter int WIDTH_CK  = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               upd,
  input  logic [NAREG-1:0][WIDTH_PRD-1:0]    next_map,
  input  logic                               snap_we,
  input  logic [WIDTH_CK-1:0]                snap_id,
  input  logic [NAREG-1:0][WIDTH_PRD-1:0]    snap_map,
  input  logic                               restore,
  input  logic [WIDTH_CK-1:0]                restore_id,
  output logic [NAREG-1:0][WIDTH_PRD-1:0]    map
);

  logic [NAREG-1:0][WIDTH_PRD-1:0] bank [NCKPT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NAREG; r++)
        map[r] <= WIDTH_PRD'(r);
      for (int k = 0; k < NCKPT; k++)
        for (int r = 0; r < NAREG; r++)
          bank[k][r] <= WIDTH_PRD'(r);
    end else begin
      if (restore)
        map <= bank[restore_id];
      else if (upd)
        map <= next_map;
      // a recovering cycle ignores the input group entirely
      if (snap_we && !restore)
        bank[snap_id] <= snap_map;
    end
  end

endmodule

// File: rtl/rename_ckpt.sv
// WAYS-wide register rename with intra-group bypass and branch checkpoints.
// Ports: decode group in, freelist pops, renamed group out, recover/free control.
module rename_ckpt
  import rename_pkg::*;
#(
  parameter int WAYS      = 4,
  parameter int WIDTH_PRD = 7,
  parameter int NCKPT     = 4,
  parameter int WIDTH_CK  = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [WAYS-1:0]               i_valid,
  input  logic [WAYS*RG_W-1:0]          i_rg,
  input  logic [WAYS-1:0]               i_br,
  input  logic [WAYS*WIDTH_PRD-1:0]     i_freelist,
  input  logic [WIDTH_PRD:0]            i_fl_cnt,
  output logic [WAYS-1:0]               o_enfreelist,
  input  logic                          i_stall,
  output logic                          o_ready,
  output logic [WAYS-1:0]               o_valid,
  output logic [WAYS*3*WIDTH_PRD-1:0]   o_prg,
  output logic [WAYS*WIDTH_PRD-1:0]     o_mtab,
  output logic [WIDTH_CK-1:0]           o_ckpt_id,
  output logic                          o_ckpt_vld,
  input  logic                          i_recover,
  input  logic [WIDTH_CK-1:0]           i_recover_id,
  input  logic                          i_ckpt_free
);

  typedef logic [NAREG-1:0][WIDTH_PRD-1:0] map_t;

  localparam logic [WIDTH_CK:0] FULL = (WIDTH_CK+1)'(NCKPT);

  logic [AREG_W-1:0]    rd   [WAYS];
  logic [AREG_W-1:0]    rs1  [WAYS];
  logic [AREG_W-1:0]    rs2  [WAYS];
  logic [WIDTH_PRD-1:0] prd  [WAYS];
  logic [WIDTH_PRD-1:0] prs1 [WAYS];
  logic [WIDTH_PRD-1:0] prs2 [WAYS];
  logic [WIDTH_PRD-1:0] old  [WAYS];

  logic [WAYS-1:0]            wr;
  logic [WAYS-1:0]            brv;
  logic [WIDTH_PRD:0]         need;
  int                         nbr;
  logic                       any_br;
  logic                       accept;
  logic                       alloc;
  logic [WAYS*3*WIDTH_PRD-1:0] prg_d;
  logic [WAYS*WIDTH_PRD-1:0]  mtab_d;

  map_t map;
  map_t next_map;
  map_t snap_map;

  logic [WIDTH_CK-1:0] head;
  logic [WIDTH_CK-1:0] tail;
  logic [WIDTH_CK-1:0] head_inc;
  logic [WIDTH_CK-1:0] tail_rec;
  logic [WIDTH_CK:0]   count;

  always_comb begin
    for (int g = 0; g < WAYS; g++) begin
      rd[g]  = i_rg[g*RG_W+RD_LSB  +: AREG_W];
      rs2[g] = i_rg[g*RG_W+RS2_LSB +: AREG_W];
      rs1[g] = i_rg[g*RG_W+RS1_LSB +: AREG_W];
      wr[g]  = i_valid[g] && (rd[g] != ZERO_REG);
      prd[g] = wr[g] ? i_freelist[g*WIDTH_PRD +: WIDTH_PRD] : '0;
    end
  end

  assign brv    = i_br & i_valid;
  assign need   = (WIDTH_PRD+1)'(popcount(32'(wr)));
  assign nbr    = popcount(32'(brv));
  assign any_br = |brv;

  // ready looks only at inputs and the checkpoint count
  assign o_ready = !i_stall && !i_recover
                && (i_fl_cnt >= need)
                && (nbr <= 1)
                && (!any_br || (count < FULL));

  assign accept       = o_ready && (|i_valid);
  assign alloc        = accept && any_br;
  assign o_enfreelist = accept ? wr : '0;

  // sources and old prd: youngest older writer wins over the table
  always_comb begin
    for (int g = 0; g < WAYS; g++) begin
      prs1[g] = map[rs1[g]];
      prs2[g] = map[rs2[g]];
      old[g]  = map[rd[g]];
      for (int j = 0; j < g; j++) begin
        if (wr[j] && (rd[j] == rs1[g])) prs1[g] = prd[j];
        if (wr[j] && (rd[j] == rs2[g])) prs2[g] = prd[j];
        if (wr[j] && (rd[j] == rd[g]))  old[g]  = prd[j];
      end
      if (rs1[g] == ZERO_REG) prs1[g] = '0;
      if (rs2[g] == ZERO_REG) prs2[g] = '0;
      if (rd[g]  == ZERO_REG) old[g]  = '0;
    end
  end

  // walk ways oldest-first; the snapshot freezes after the branch way
  always_comb begin
    next_map = map;
    snap_map = map;
    for (int g = 0; g < WAYS; g++) begin
      if (wr[g])  next_map[rd[g]] = prd[g];
      if (brv[g]) snap_map = next_map;
    end
  end

  always_comb begin
    for (int g = 0; g < WAYS; g++) begin
      prg_d[g*3*WIDTH_PRD +: 3*WIDTH_PRD] = {prd[g], prs2[g], prs1[g]};
      mtab_d[g*WIDTH_PRD +: WIDTH_PRD]    = old[g];
    end
  end

  rename_maptable_ckpt #(
    .WIDTH_PRD (WIDTH_PRD),
    .NCKPT     (NCKPT),
    .WIDTH_CK  (WIDTH_CK)
  ) u_map (
    .clk        (i_clk),
    .rst        (i_rst),
    .upd        (accept),
    .next_map   (next_map),
    .snap_we    (alloc),
    .snap_id    (tail),
    .snap_map   (snap_map),
    .restore    (i_recover),
    .restore_id (i_recover_id),
    .map        (map)
  );

  assign head_inc = head + WIDTH_CK'(i_ckpt_free);
  assign tail_rec = i_recover_id + WIDTH_CK'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (i_recover) begin
      head  <= head_inc;
      tail  <= tail_rec;
      count <= {1'b0, tail_rec - head_inc};
    end else begin
      head  <= head_inc;
      tail  <= tail + WIDTH_CK'(alloc);
      count <= count + (WIDTH_CK+1)'(alloc)
                     - (WIDTH_CK+1)'(i_ckpt_free);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid    <= '0;
      o_prg      <= '0;
      o_mtab     <= '0;
      o_ckpt_id  <= '0;
      o_ckpt_vld <= 1'b0;
    end else if (i_recover) begin
      o_valid    <= '0;
      o_ckpt_vld <= 1'b0;
    end else if (!i_stall) begin
      if (accept) begin
        o_valid    <= i_valid;
        o_prg      <= prg_d;
        o_mtab     <= mtab_d;
        o_ckpt_id  <= tail;
        o_ckpt_vld <= any_br;
      end else begin
        o_valid    <= '0;
        o_ckpt_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rename_ckpt.sv
// Scoreboard bench for rename_ckpt: reference map/checkpoint model,
// expected output groups queued at drive time and checked one cycle later.
module tb_rename_ckpt;

  localparam int WAYS = 4;
  localparam int W    = 7;
  localparam int NCK  = 4;
  localparam int CKW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [WAYS-1:0]   valid;
  logic [WAYS*15-1:0] rg;
  logic [WAYS-1:0]   br;
  logic [WAYS*W-1:0] fl;
  logic [W:0]        fl_cnt;
  logic [WAYS-1:0]   enfl;
  logic              stall;
  logic              ready;
  logic [WAYS-1:0]   ov;
  logic [WAYS*3*W-1:0] prg;
  logic [WAYS*W-1:0] mtab;
  logic [CKW-1:0]    ckid;
  logic              ckvld;
  logic              rec;
  logic [CKW-1:0]    recid;
  logic              ckfree;

  always #5 clk = ~clk;

  rename_ckpt #(
    .WAYS(WAYS), .WIDTH_PRD(W), .NCKPT(NCK), .WIDTH_CK(CKW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (valid),
    .i_rg         (rg),
    .i_br         (br),
    .i_freelist   (fl),
    .i_fl_cnt     (fl_cnt),
    .o_enfreelist (enfl),
    .i_stall      (stall),
    .o_ready      (ready),
    .o_valid      (ov),
    .o_prg        (prg),
    .o_mtab       (mtab),
    .o_ckpt_id    (ckid),
    .o_ckpt_vld   (ckvld),
    .i_recover    (rec),
    .i_recover_id (recid),
    .i_ckpt_free  (ckfree)
  );

  typedef struct {
    logic [WAYS-1:0]     v;
    logic [WAYS*3*W-1:0] prg;
    logic [WAYS*W-1:0]   mtab;
    logic [CKW-1:0]      id;
    logic                cv;
    bit                  full;
    bit                  cvchk;
  } exp_t;

  exp_t q[$];
  exp_t last;

  int n_vec = 0;
  int n_bad = 0;

  int m_map [32];
  int m_ck  [NCK][32];
  int m_head, m_tail, m_count;

  int g_rd [WAYS];
  int g_rs2[WAYS];
  int g_rs1[WAYS];
  int g_fl [WAYS];

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_way(int g, int d, int s2, int s1, int f);
    g_rd[g]  = d;
    g_rs2[g] = s2;
    g_rs1[g] = s1;
    g_fl[g]  = f;
  endtask

  task automatic clr_ways();
    for (int g = 0; g < WAYS; g++) set_way(g, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_map[r] = r;
      for (int k = 0; k < NCK; k++) m_ck[k][r] = r;
    end
    m_head  = 0;
    m_tail  = 0;
    m_count = 0;
    last    = '{default: '0};
    q.delete();
  endtask

  task automatic idle_inputs();
    valid  = '0;
    br     = '0;
    rg     = '0;
    fl     = '0;
    fl_cnt = '0;
    stall  = 1'b0;
    rec    = 1'b0;
    recid  = '0;
    ckfree = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_valid", 128'(ov), 128'(0));
    chk("rst_prg",   128'(prg), 128'(0));
    chk("rst_mtab",  128'(mtab), 128'(0));
    chk("rst_ckvld", 128'(ckvld), 128'(0));
    chk("rst_ckid",  128'(ckid), 128'(0));
    rst = 1'b0;
  endtask

  task automatic apply(logic [WAYS-1:0] v, logic [WAYS-1:0] b, int cnt,
                       bit st, bit rc, int rid, bit fr);
    exp_t e;
    int run [32];
    int snap[32];
    int need, nbr, p1, p2, om, pd;
    bit exp_ready, acc;
    logic [WAYS-1:0] wm;

    valid  = v;
    br     = b;
    stall  = st;
    rec    = rc;
    recid  = CKW'(rid);
    ckfree = fr;
    fl_cnt = (W+1)'(cnt);
    for (int g = 0; g < WAYS; g++) begin
      rg[g*15 +: 15] = {5'(g_rd[g]), 5'(g_rs2[g]), 5'(g_rs1[g])};
      fl[g*W +: W]   = W'(g_fl[g]);
    end
    assert (!(fr && m_count == 0)) else $error("ckpt free with empty queue");
    #1;

    need = 0;
    nbr  = 0;
    wm   = '0;
    for (int g = 0; g < WAYS; g++) begin
      if (v[g] && g_rd[g] != 0) begin
        need++;
        wm[g] = 1'b1;
      end
      if (v[g] && b[g]) nbr++;
    end
    exp_ready = !st && !rc && (cnt >= need) && (nbr <= 1)
             && (nbr == 0 || m_count < NCK);
    acc = exp_ready && (v != 0);
    chk("ready", 128'(ready), 128'(exp_ready));
    chk("enfl",  128'(enfl), 128'(acc ? wm : 4'b0));

    e = '{default: '0};
    run  = m_map;
    snap = m_map;
    if (rc) begin
      e = last;
      e.v = '0;
      e.full = 0;
      e.cvchk = 0;
    end else if (st) begin
      e = last;
    end else if (acc) begin
      for (int g = 0; g < WAYS; g++) begin
        if (v[g]) begin
          p1 = (g_rs1[g] == 0) ? 0 : run[g_rs1[g]];
          p2 = (g_rs2[g] == 0) ? 0 : run[g_rs2[g]];
          om = (g_rd[g] == 0) ? 0 : run[g_rd[g]];
          pd = (g_rd[g] == 0) ? 0 : g_fl[g];
          e.prg[g*3*W +: 3*W] = {W'(pd), W'(p2), W'(p1)};
          e.mtab[g*W +: W]    = W'(om);
          if (g_rd[g] != 0) run[g_rd[g]] = pd;
          if (b[g]) snap = run;
        end
      end
      e.v     = v;
      e.cv    = (nbr == 1);
      e.id    = CKW'(m_tail);
      e.full  = 1;
      e.cvchk = 1;
    end else begin
      e.cvchk = 1;
    end

    if (rc) begin
      m_head  = (m_head + int'(fr)) % NCK;
      m_map   = m_ck[rid];
      m_tail  = (rid + 1) % NCK;
      m_count = (m_tail - m_head + NCK) % NCK;
    end else begin
      if (acc) begin
        m_map = run;
        if (nbr == 1) begin
          m_ck[m_tail] = snap;
          m_tail = (m_tail + 1) % NCK;
          m_count++;
        end
      end
      if (fr) begin
        m_head = (m_head + 1) % NCK;
        m_count--;
      end
    end
    q.push_back(e);

    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("valid", 128'(ov), 128'(e.v));
    if (e.cvchk) chk("ckvld", 128'(ckvld), 128'(e.cv));
    if (e.full) begin
      for (int g = 0; g < WAYS; g++) begin
        if (e.v[g]) begin
          chk("prg",  128'(prg[g*3*W +: 3*W]), 128'(e.prg[g*3*W +: 3*W]));
          chk("mtab", 128'(mtab[g*W +: W]), 128'(e.mtab[g*W +: W]));
        end
      end
      if (e.cv) chk("ckid", 128'(ckid), 128'(e.id));
    end
    last = e;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int rid, off, cnt;
    logic [WAYS-1:0] v, b;
    bit st, rc, fr;

    idle_inputs();
    clr_ways();
    do_reset();
    chk("rst_ready", 128'(ready), 128'(1));

    // single way, identity map
    clr_ways();
    set_way(0, 3, 1, 2, 40);
    set_way(1, 0, 0, 0, 41);
    set_way(2, 0, 0, 0, 42);
    set_way(3, 0, 0, 0, 43);
    apply(4'b0001, 4'b0000, 10, 0, 0, 0, 0);
    chk("t1_prg0",  128'(prg[20:0]), 128'({7'd40, 7'd1, 7'd2}));
    chk("t1_mtab0", 128'(mtab[6:0]), 128'(3));

    // RAW/WAW chain on x5
    clr_ways();
    set_way(0, 5, 0, 0, 40);
    set_way(1, 5, 0, 5, 41);
    set_way(2, 6, 5, 0, 42);
    apply(4'b0111, 4'b0000, 10, 0, 0, 0, 0);
    chk("t2_prs1_w1", 128'(prg[21 +: 7]), 128'(40));
    chk("t2_mtab1",   128'(mtab[7 +: 7]), 128'(40));
    chk("t2_prs2_w2", 128'(prg[42+7 +: 7]), 128'(41));
    clr_ways();
    set_way(0, 0, 0, 5, 0);
    apply(4'b0001, 4'b0000, 10, 0, 0, 0, 0);
    chk("t3_x5", 128'(prg[6:0]), 128'(41));

    // rd=0 everywhere, empty freelist
    clr_ways();
    for (int g = 0; g < WAYS; g++) set_way(g, 0, g + 1, 5, 90 + g);
    apply(4'b1111, 4'b0000, 0, 0, 0, 0, 0);

    // branch in way 1, then recover to it
    clr_ways();
    set_way(0, 8, 1, 1, 48);
    set_way(1, 0, 2, 3, 0);
    set_way(2, 7, 1, 1, 50);
    apply(4'b0111, 4'b0010, 10, 0, 0, 0, 0);
    rid = (m_tail + NCK - 1) % NCK;
    clr_ways();
    set_way(0, 9, 1, 1, 60);
    apply(4'b0001, 4'b0000, 10, 0, 1, rid, 0);
    clr_ways();
    set_way(0, 0, 8, 7, 0);
    apply(4'b0001, 4'b0000, 10, 0, 0, 0, 0);
    chk("t5_x7", 128'(prg[6:0]), 128'(7));
    chk("t5_x8", 128'(prg[13:7]), 128'(48));
    clr_ways();
    apply(4'b0000, 4'b0000, 0, 0, 0, 0, 1);

    // fill every checkpoint, then one more branch group
    for (int i = 0; i < NCK; i++) begin
      clr_ways();
      set_way(0, 10 + i, 0, 0, 60 + i);
      apply(4'b0001, 4'b0001, 10, 0, 0, 0, 0);
    end
    clr_ways();
    set_way(0, 20, 0, 0, 70);
    apply(4'b0001, 4'b0001, 10, 0, 0, 0, 0);
    apply(4'b0001, 4'b0001, 10, 0, 0, 0, 1);
    apply(4'b0001, 4'b0001, 10, 0, 0, 0, 0);
    chk("t6_wrap_id", 128'(ckid), 128'(1));
    while (m_count > 0) begin
      clr_ways();
      apply(4'b0000, 4'b0000, 0, 0, 0, 0, 1);
    end

    // stall for three cycles, then release
    clr_ways();
    set_way(0, 12, 3, 4, 80);
    set_way(1, 13, 12, 12, 81);
    repeat (3) apply(4'b0011, 4'b0000, 10, 1, 0, 0, 0);
    apply(4'b0011, 4'b0000, 10, 0, 0, 0, 0);
    clr_ways();
    apply(4'b0000, 4'b0000, 10, 0, 0, 0, 0);

    // random traffic
    for (int it = 0; it < 80; it++) begin
      for (int g = 0; g < WAYS; g++)
        set_way(g, ($urandom % 4 == 0) ? 0 : int'($urandom_range(1, 31)),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(1, 127)));
      v = 4'($urandom);
      b = ($urandom % 3 == 0) ? (4'b0001 << ($urandom % 4)) : 4'b0000;
      if (it % 11 == 5) begin
        b = 4'b0011;
        v = v | 4'b0011;
      end
      st  = ($urandom % 5 == 0);
      rc  = (m_count > 0) && ($urandom % 8 == 0);
      fr  = (m_count > 0) && ($urandom % 4 == 0);
      cnt = int'($urandom_range(0, 6));
      rid = 0;
      if (rc) begin
        off = int'($urandom_range(0, m_count - 1));
        if (off == NCK - 1) off = 0;
        rid = (m_head + off) % NCK;
      end
      apply(v, b, cnt, st, rc, rid, fr);
    end

    // reset in the middle of a busy cycle
    clr_ways();
    set_way(0, 4, 4, 4, 99);
    valid  = 4'b0001;
    br     = 4'b0001;
    fl_cnt = 8'd10;
    rg[14:0] = {5'd4, 5'd4, 5'd4};
    do_reset();
    idle_inputs();
    clr_ways();
    set_way(0, 0, 12, 5, 0);
    set_way(1, 0, 13, 7, 0);
    apply(4'b0011, 4'b0000, 10, 0, 0, 0, 0);
    chk("rst_map_x5", 128'(prg[6:0]), 128'(5));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
